cordic_atan2: RTL and testbench

- Iterative CORDIC vectoring block: converts a signed I/Q sample pair into a phase word and a magnitude.
- Phase output uses the same convention as the NCO phase fed to the sine/cosine LUT: 2^psz counts per full circle, MSB = half, next bit = quadrant.
- Sits on the receive/demod side, recovering phase from quadrature samples, so results can be compared directly against the NCO phase accumulator.

---
 rtl/cordic_atan2.sv | 153 +++++++++++++++
 tb/tb_cordic_atan2.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_atan2.sv
// cordic_atan2: iterative CORDIC vectoring, signed I/Q -> phase word (2^psz per circle) and magnitude.
// Optional build macro CORDIC_GAIN_COMP_EN scales mag by ~1/K with one extra output cycle.
module cordic_atan2 #(
  parameter int isz  = 18,
  parameter int psz  = 12,
  parameter int iter = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic signed [isz-1:0] i_in,
  input  logic signed [isz-1:0] q_in,
  output logic                  busy,
  output logic                  valid,
  output logic [psz-1:0]        phs,
  output logic [isz:0]          mag
);
  localparam int xw = isz + 2;
  localparam int zw = psz + 4;
  // angle table is held at 2^24 counts per circle and rounded down to z resolution
  localparam int sh = 20 - psz;
  localparam logic [23:0] rnd = sh > 0 ? 24'(1) << (sh - 1) : 24'd0;
  typedef enum logic [1:0] {IDLE, ROT, OUT} state_t;
  state_t state_q, state_d;
  logic signed [xw-1:0] x_q, x_d, y_q, y_d, xs, ys, ie, qe;
  logic [zw-1:0] z_q, z_d;
  logic [3:0] k_q, k_d;
  logic zr_q, zr_d, busy_q, busy_d, valid_q, valid_d, done;
  logic [psz-1:0] phs_q, phs_d;
  logic [isz:0] mag_q, mag_d, mag_src;

  function automatic logic [zw-1:0] atan_tab(input logic [3:0] k);
    logic [23:0] t;
    case (k)
      4'd0:    t = 24'd2097152;
      4'd1:    t = 24'd1238021;
      4'd2:    t = 24'd654136;
      4'd3:    t = 24'd332050;
      4'd4:    t = 24'd166669;
      4'd5:    t = 24'd83415;
      4'd6:    t = 24'd41718;
      4'd7:    t = 24'd20860;
      4'd8:    t = 24'd10430;
      4'd9:    t = 24'd5215;
      4'd10:   t = 24'd2608;
      4'd11:   t = 24'd1304;
      4'd12:   t = 24'd652;
      4'd13:   t = 24'd326;
      4'd14:   t = 24'd163;
      default: t = 24'd81;
    endcase
    return zw'((t + rnd) >> sh);
  endfunction

  assign ie = xw'(i_in);
  assign qe = xw'(q_in);

`ifdef CORDIC_GAIN_COMP_EN
  logic [isz:0] g_q, g_d;
  logic o_q, o_d;
  // first OUT cycle: x * (1/2 + 1/8 - 1/64 - 1/512 - 1/4096) ~= x / K
  always_comb begin
    g_d = (isz+1)'((x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9) - (x_q >>> 12));
    o_d = (state_q == OUT) && !o_q;
  end
  // gain-compensation pipeline register and OUT sub-cycle flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      g_q <= '0;
      o_q <= 1'b0;
    end else begin
      g_q <= g_d;
      o_q <= o_d;
    end
  assign done = o_q;
  assign mag_src = g_q;
`else
  assign done = 1'b1;
  assign mag_src = x_q[isz:0];
`endif

  // capture with half-plane pre-rotation, one micro-rotation per ROT cycle, publish in OUT
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    k_d = k_q;
    zr_d = zr_q;
    busy_d = busy_q;
    valid_d = 1'b0;
    phs_d = phs_q;
    mag_d = mag_q;
    xs = x_q >>> k_q;
    ys = y_q >>> k_q;
    case (state_q)
      IDLE: if (start) begin
        x_d = i_in[isz-1] ? -ie : ie;
        y_d = i_in[isz-1] ? -qe : qe;
        z_d = i_in[isz-1] ? zw'(1) << (zw - 1) : '0;
        zr_d = (i_in == '0) && (q_in == '0);
        k_d = '0;
        busy_d = 1'b1;
        state_d = ROT;
      end
      ROT: begin
        x_d = y_q[xw-1] ? x_q - ys : x_q + ys;
        y_d = y_q[xw-1] ? y_q + xs : y_q - xs;
        z_d = y_q[xw-1] ? z_q - atan_tab(k_q) : z_q + atan_tab(k_q);
        k_d = k_q + 4'd1;
        state_d = k_q == 4'(iter - 1) ? OUT : ROT;
      end
      default: if (done) begin
        phs_d = zr_q ? '0 : psz'((z_q + zw'(8)) >> 4);
        mag_d = mag_src;
        valid_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // all state and registered outputs; reset abandons any conversion in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      k_q <= '0;
      zr_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      phs_q <= '0;
      mag_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      k_q <= k_d;
      zr_q <= zr_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      phs_q <= phs_d;
      mag_q <= mag_d;
    end

  assign busy = busy_q;
  assign valid = valid_q;
  assign phs = phs_q;
  assign mag = mag_q;
endmodule

// File: tb/tb_cordic_atan2.sv
// tb_cordic_atan2: directed and random checks of cordic_atan2 against a real-arithmetic atan2/hypot model.
module tb_cordic_atan2;
  localparam int ISZ = 18;
  localparam int PSZ = 12;
  localparam int ITER = 12;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 2;
  localparam real MSCALE = 1.0;
`else
  localparam int LAT = ITER + 1;
  localparam real MSCALE = 1.646760258;
`endif
  localparam real PI = 3.14159265358979;
  localparam real CIRC = 4096.0;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic signed [ISZ-1:0] i_in = '0, q_in = '0;
  logic busy, valid;
  logic [PSZ-1:0] phs;
  logic [ISZ:0] mag;
  int checks = 0, errors = 0;

  cordic_atan2 #(.isz(ISZ), .psz(PSZ), .iter(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i_in(i_in), .q_in(q_in),
    .busy(busy), .valid(valid), .phs(phs), .mag(mag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_phs(input string tag, input int i, input int q);
    real e, d;
    e = $atan2(real'(q), real'(i)) / (2.0 * PI) * CIRC;
    if (e < 0.0) e += CIRC;
    d = real'(phs) - e;
    if (d >= CIRC / 2.0) d -= CIRC;
    if (d < -CIRC / 2.0) d += CIRC;
    checks++;
    assert ((d <= 1.0 && d >= -1.0) === 1'b1) else begin
      errors++;
      $error("FAIL %s phs: got %0d expected %0.2f +-1", tag, phs, e);
    end
  endtask

  task automatic chk_mag(input string tag, input int i, input int q);
    real e, tol;
    e = MSCALE * $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
    tol = e * 0.001 + 6.0;
    checks++;
    assert ((real'(mag) - e <= tol && e - real'(mag) <= tol) === 1'b1) else begin
      errors++;
      $error("FAIL %s mag: got %0d expected %0.1f +-%0.1f", tag, mag, e, tol);
    end
  endtask

  // one conversion: start pulse, latency, result, then hold of outputs
  task automatic run(input string tag, input int i, input int q);
    int n, p;
    @(negedge clk);
    i_in = ISZ'(i);
    q_in = ISZ'(q);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy"}, int'(busy), 1);
    n = 0;
    while (!valid && n < LAT + 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, LAT);
    chk({tag, " busy_lo"}, int'(busy), 0);
    if (i == 0 && q == 0) begin
      chk({tag, " phs0"}, int'(phs), 0);
      chk({tag, " mag0"}, int'(mag), 0);
    end else begin
      chk_phs(tag, i, q);
      chk_mag(tag, i, q);
    end
    p = int'(phs);
    @(negedge clk);
    chk({tag, " pulse"}, int'(valid), 0);
    chk({tag, " hold"}, int'(phs), p);
  endtask

  initial begin
    int n, nv, bh, ri, rq;
    // reset state
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst valid", int'(valid), 0);
    chk("rst phs", int'(phs), 0);
    chk("rst mag", int'(mag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // axes, diagonals, full-scale corner, wrap, zero
    run("pos_i", 10000, 0);
    run("pos_q", 0, 10000);
    run("neg_i", -10000, 0);
    run("neg_q", 0, -10000);
    run("diag1", 7071, 7071);
    run("diag3", -7071, -7071);
    run("corner", -131072, -131072);
    run("wrap", 10000, -10);
    run("zero", 0, 0);
    run("q2", -20000, 35000);
    // start held high: accepted again in each valid cycle
    @(negedge clk);
    i_in = ISZ'(7071);
    q_in = ISZ'(-7071);
    start = 1'b1;
    n = 0;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b first", int'(valid), 1);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!valid && n < 40);
      chk("b2b period", n, LAT + 1);
    end
    start = 1'b0;
    chk_phs("b2b", 7071, -7071);
    @(negedge clk);
    chk("b2b idle", int'(busy), 0);
    // start pulses mid-conversion are ignored
    @(negedge clk);
    i_in = ISZ'(0);
    q_in = ISZ'(10000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    i_in = ISZ'(-10000);
    q_in = ISZ'(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    bh = 1;
    for (int c = 0; c < 2 * LAT + 4; c++) begin
      if (valid) begin
        nv++;
        if (nv == 1) chk_phs("ignore", 0, 10000);
      end else if (nv == 0 && !busy) bh = 0;
      @(negedge clk);
    end
    chk("ignore count", nv, 1);
    chk("ignore busy", bh, 1);
    // reset in the middle of ROT
    run("pre_rst", 3000, 4000);
    @(negedge clk);
    i_in = ISZ'(-9000);
    q_in = ISZ'(2000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst busy", int'(busy), 0);
    chk("mid_rst valid", int'(valid), 0);
    chk("mid_rst phs", int'(phs), 0);
    chk("mid_rst mag", int'(mag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("stale valid", nv, 0);
    run("post_rst", -5000, 3000);
    // random vectors, magnitude kept well above the accuracy floor
    for (int r = 0; r < 24; r++) begin
      n = 0;
      do begin
        ri = int'($urandom_range(0, 262143)) - 131072;
        rq = int'($urandom_range(0, 262143)) - 131072;
        n++;
      end while (real'(ri) * real'(ri) + real'(rq) * real'(rq) < 16777216.0 && n < 100);
      run("rand", ri, rq);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
